// File: rtl/mem_bus_responder.sv
// mem_bus_responder: memory-side responder for the 16-bit multicycle CPU.
// Decodes RAM vs I/O, applies RAM wait states and instruction write protection.
module mem_bus_responder #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] IO_BASE     = 16'hCFFD,
  parameter logic [WIDTH-1:0] PROT_TOP    = 16'h5FFF,
  parameter int               WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             we,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             ready,
  output logic             wp_err,
  output logic             ram_en,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] io_out
);

  localparam logic [3:0] WAIT_LD =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [WIDTH-1:0] IO_IN_ADDR = IO_BASE + WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_capture;
  logic             w_addr_io;
  logic             w_addr_prot;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic             r_we;
  logic             r_io;
  logic             r_prot;
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_rdata;
  logic [WIDTH-1:0] r_io_out;

  assign w_addr_io   = (addr >= IO_BASE);
  assign w_addr_prot = (addr <= PROT_TOP);
  assign rdata       = r_rdata;
  assign io_out      = r_io_out;

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and per-state bus outputs.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    ready     = 1'b0;
    wp_err    = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (r_state)
      S_IDLE: begin
        if (req) begin
          w_accept = 1'b1;
          if (w_addr_io)            w_next = S_CAPTURE;
          else if (WAIT_CYCLES > 0) w_next = S_WAIT;
          else                      w_next = S_ACCESS;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        ram_en    = 1'b1;
        ram_we    = r_we & ~r_prot;
        ram_addr  = r_addr;
        ram_wdata = r_wdata;
        w_next    = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_capture = 1'b1;
        w_next    = S_DONE;
      end
      S_DONE: begin
        ready  = 1'b1;
        wp_err = r_we & r_prot & ~r_io;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Latch the request and its region decode on acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_io    <= 1'b0;
      r_prot  <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= addr;
      r_wdata <= wdata;
      r_we    <= we;
      r_io    <= w_addr_io;
      r_prot  <= w_addr_prot;
    end
  end

  // Wait-state down-counter, loaded on acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= WAIT_LD;
    end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Two-flop synchronizer for the external input word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= io_in;
      r_sync2 <= r_sync1;
    end
  end

  // Load data capture; stores leave the last load value in place.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
    end else if (w_capture && !r_we) begin
      if (!r_io)                    r_rdata <= ram_rdata;
      else if (r_addr == IO_BASE)   r_rdata <= r_io_out;
      else if (r_addr == IO_IN_ADDR) r_rdata <= r_sync2;
      else                          r_rdata <= '0;
    end
  end

  // I/O output register, written only by stores to the base I/O address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_io_out <= '0;
    end else if (w_capture && r_we && r_io && r_addr == IO_BASE) begin
      r_io_out <= r_wdata;
    end
  end

endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Memory-side responder for the 16-bit multicycle CPU datapath: accepts the processor's single-word read/write requests (address, store data, write strobe), decodes them into the RAM window or the memory-mapped I/O window, and returns load data with a one-cycle `ready` pulse. It sits between the processor's memory port and a synchronous single-port block RAM. It also owns the I/O output register, the input synchronizer, and write protection of the instruction region.

## Interface
- `WIDTH`, 16, data and address width.
- `IO_BASE`, 16'hCFFD, first I/O address. Addresses `>= IO_BASE` are I/O; all lower addresses are RAM.
- `PROT_TOP`, 16'h5FFF, highest write-protected RAM address, inclusive. The protected range is 0x0000..PROT_TOP.
- `WAIT_CYCLES`, 2, extra RAM wait states, 0..15, implemented with a 4-bit counter.

Ports:
- `clk`, input, 1, single clock; all state changes on the rising edge.
- `reset`, input, 1, asynchronous, active-low. Takes effect immediately on assertion and is released synchronously to `clk`.
- `req`, input, 1, access request; held high until `ready` is seen.
- `we`, input, 1, 1 = store, 0 = load; stable while `req` is high.
- `addr`, input, WIDTH, word address; stable while `req` is high.
- `wdata`, input, WIDTH, store data; stable while `req` is high.
- `rdata`, output, WIDTH, load data; registered, valid in the `ready` cycle and held until the next load completes.
- `ready`, output, 1, one-cycle completion pulse.
- `wp_err`, output, 1, pulses together with `ready` when a store to the protected range was dropped.
- `ram_en`, output, 1, RAM access enable.
- `ram_we`, output, 1, RAM write enable.
- `ram_addr`, output, WIDTH, RAM address.
- `ram_wdata`, output, WIDTH, RAM write data.
- `ram_rdata`, input, WIDTH, RAM read data; valid the cycle after the `ram_en` cycle.
- `io_in`, input, WIDTH, asynchronous external input.
- `io_out`, output, WIDTH, I/O output register.

## Operation
- **FSM states:** IDLE, WAIT, ACCESS, CAPTURE, DONE.
- **IDLE:** when `req` is 1, latch `addr`, `we`, `wdata` and the region decode.
  - RAM access: go to WAIT if `WAIT_CYCLES > 0` (counter loaded with `WAIT_CYCLES - 1`); otherwise go to ACCESS.
  - I/O access: go to CAPTURE.
- **WAIT:** count the counter down to 0, then go to ACCESS.
- **ACCESS (RAM only):**
  - `ram_en = 1` and `ram_addr` = latched address.
  - `ram_we = we`, except that `ram_we = 0` when the latched address `<= PROT_TOP`.
  - `ram_wdata` = latched data.
  - Next state: CAPTURE.
- **CAPTURE:**
  - RAM load: `rdata <= ram_rdata`.
  - I/O load at `IO_BASE`: `rdata <=` `io_out`.
  - I/O load at `IO_BASE+1`: `rdata <=` synchronized `io_in`.
  - I/O load at any other I/O address: `rdata <=` 0x0000.
  - I/O store to `IO_BASE`: `io_out <= wdata`. Stores to other I/O addresses are ignored with no error.
  - Stores never modify `rdata`.
  - Next state: DONE.
- **DONE:**
  - `ready = 1`.
  - `wp_err = 1` if the access was a store to a RAM address `<= PROT_TOP`.
  - Next state is always IDLE.
- **Requester rule:** deassert `req` on the edge after `ready`. A `req` still high in IDLE is treated as a new access.
- **`io_in` synchronizer:** two flops, running continuously.
- **Address boundaries:**
  - 0xCFFC is RAM; 0xCFFD is I/O.
  - 0x5FFF is protected; 0x6000 is writable.
  - Loads from the protected range are always permitted.

## Timing
- **Reset values:** `reset` low forces IDLE. All of the following clear to 0 / 0x0000: `ready`, `wp_err`, `ram_en`, `ram_we`, `ram_addr`, `ram_wdata`, `rdata`, `io_out`, the synchronizer flops and the wait counter.
- **Reset mid-access:** the access is abandoned, and no `ready` pulse follows.
- **RAM latency:** with `req` first sampled high in IDLE at edge 0, `ready` is high in cycle `3 + WAIT_CYCLES`. With the default of 2, that is cycle 5.
- **I/O latency:** `ready` is high in cycle 2.
- **Pipelining:** none; at most one outstanding access.
- **Minimum spacing:** `ready` to next accepted request is 1 cycle (the IDLE cycle).
- **`ram_en`:** high for exactly one cycle per RAM access. Never asserted for I/O accesses.
- **`io_in` latency:** a change becomes visible to loads after 2 edges.

## Test plan
- **RAM store/load, `WAIT_CYCLES=2`:** store 0xBEEF to 0x7000, then load 0x7000.
  - Each access gives exactly one `ready`, 5 cycles after acceptance.
  - The load returns `rdata` 0xBEEF.
  - `ram_we` is high exactly once.
- **Write protection:** store 0x1234 to 0x5FFF.
  - `ram_en` pulses with `ram_we = 0`; `wp_err` and `ready` are high together.
  - Storing to 0x6000 gives `ram_we = 1` and `wp_err = 0`.
- **I/O:**
  - Store 0x00A5 to 0xCFFD: `io_out` becomes 0x00A5, `ready` at cycle 2, `ram_en` never high.
  - Load 0xCFFD returns 0x00A5.
  - Load 0xCFFF returns 0x0000.
- **Input synchronizer:** drive `io_in` to 0x5A5A, wait 2 cycles, load 0xCFFE; `rdata` is 0x5A5A.
- **Boundary decode:** a load from 0xCFFC asserts `ram_en`; a load from 0xCFFD does not.
- **Reset mid-access:** assert `reset` low during WAIT of a RAM store.
  - Outputs clear immediately; no `ready` pulse.
  - After release, a new load to 0x7000 completes normally.
